mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits, with a 64-bit hi:lo result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  operation select: 0 = signed multiply (mult), 1 = signed divide (div).
REQ-006 a  input  32  operand A (multiplicand or dividend), taken from register A.
REQ-007 b  input  32  operand B (multiplier or divisor), taken from register B.
REQ-008 hi  output  32  result high word; feeds the hi register input path.
REQ-009 lo  output  32  result low word; feeds the lo register input path.
REQ-010 busy  output  1  high while the block is in RUN.
REQ-011 done  output  1  one-cycle pulse; hi/lo are valid while it is high.
REQ-012 div_zero  output  1  one-cycle pulse together with done when a div has b = 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL latch a, b and op at that edge.
- Latched operands are used for the whole operation; later changes on a/b SHALL have no effect.
- If op=0, or op=1 with b≠0, the FSM goes to RUN with the iteration counter at 0.
- If op=1 and b=0, the FSM goes directly to DONE with div_zero=1, and hi/lo SHALL be unchanged.
REQ-015 RUN SHALL perform exactly 32 iterations, one per rising edge.
- On the 32nd edge the FSM goes to DONE and the final result is loaded into hi/lo.
- Latency: done is high in the cycle after edge 32, counting the start-sampling edge as edge 0.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE.
- done=1 throughout DONE; div_zero=1 only for the zero-divisor case.
REQ-017 Multiply SHALL produce the exact 64-bit two's-complement product.
- hi = bits 63:32, lo = bits 31:0.
- Implementation is shift-add or radix-2 Booth, with operand sign correction.
REQ-018 Divide SHALL compute a signed quotient truncated toward zero.
- lo = quotient; hi = remainder carrying the dividend's sign, with |hi| < |b|.
- Implementation is restoring or non-restoring on magnitudes, with final sign fix-up.
REQ-019 Boundary case -2147483648 / -1 SHALL give lo=0x80000000 (wrapped) and hi=0x00000000, with no flag.
REQ-020 start asserted while in RUN or DONE SHALL be ignored; it is not queued.
REQ-021 hi and lo SHALL hold their last values at all times except the RUN→DONE load edge.
- Intermediate partial results SHALL NOT appear on hi/lo.
REQ-022 busy SHALL be high in RUN only; done and div_zero SHALL be low outside DONE.

Reset
REQ-023 reset low SHALL immediately force the following, in any state including mid-RUN:
- state = IDLE, counter = 0;
- hi = lo = 0x00000000;
- busy = done = div_zero = 0;
- latched operands cleared.
REQ-024 An operation interrupted by reset SHALL be discarded.
- The first start sampled after reset rises SHALL begin a fresh operation.

Verification
REQ-025 mult a=7, b=0xFFFFFFFD (-3) -> done exactly 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
REQ-026 div a=17, b=0xFFFFFFFB (-5) -> lo=0xFFFFFFFD (-3), hi=0x00000002; second case a=-17, b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
REQ-027 div with b=0 and previous hi/lo = 0x1234/0x5678 -> done and div_zero high one cycle after start, hi/lo still 0x1234/0x5678, busy never high.
REQ-028 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; mult a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-029 mult started, then start pulsed with new operands at iteration 10 and a/b changed -> result equals the original operands' product, and exactly one done pulse.
REQ-030 reset pulled low at iteration 15 of a mult -> outputs zero immediately without a clock edge; after release, a new div 100/7 gives lo=14, hi=2.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The requester drives start/op/a/b; the unit returns hi/lo and status pulses.
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
  modport slave  (input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// 32-iteration signed multiply (shift-add) / divide (restoring) on operand magnitudes,
// with sign fix-up applied only on the final load into hi/lo.
module mult_div_unit (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic        op_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] opb_reg;
  logic [63:0] acc_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        div_zero_reg;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] addend;
  logic [32:0] mul_sum;
  logic [31:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign a_mag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_addend
      assign addend[gi] = acc_reg[0] & opb_reg[gi];
    end
  endgenerate

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, addend};
  assign div_shift = {acc_reg[62:32], acc_reg[31]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, opb_reg};

  always_comb begin
    acc_next = {mul_sum, acc_reg[31:1]};
    if (op_reg) begin
      if (div_diff[32])
        acc_next = {div_shift, acc_reg[30:0], 1'b0};
      else
        acc_next = {div_diff[31:0], acc_reg[30:0], 1'b1};
    end
  end

  assign prod_fix = neg_q_reg ? (~acc_next + 64'd1) : acc_next;
  assign quo_fix  = neg_q_reg ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
  assign rem_fix  = neg_r_reg ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      op_reg       <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      opb_reg      <= 32'd0;
      acc_reg      <= 64'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg    <= bus.op;
            neg_q_reg <= bus.a[31] ^ bus.b[31];
            neg_r_reg <= bus.a[31];
            opb_reg   <= b_mag;
            acc_reg   <= {32'd0, a_mag};
            cnt_reg   <= 5'd0;
            if (bus.op && (bus.b == 32'd0)) begin
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              div_zero_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            if (op_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              hi_reg <= prod_fix[63:32];
              lo_reg <= prod_fix[31:0];
            end
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          done_reg     <= 1'b0;
          div_zero_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit_if bus ();

  mult_div_unit dut (.clk(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero.
  task automatic model(input bit o, input logic [31:0] x, input logic [31:0] y, output bit mdz);
    longint sx, sy, p, q, r;
    logic [63:0] pv, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mdz = 1'b0;
    if (!o) begin
      p = sx * sy; pv = p;
      m_hi = pv[63:32]; m_lo = pv[31:0];
    end else if (y == 32'd0) begin
      mdz = 1'b1;
    end else begin
      q = sx / sy; r = sx % sy; qv = q; rv = r;
      m_hi = rv[31:0]; m_lo = qv[31:0];
    end
  endtask

  // Issue one op, scramble a/b after the sampling edge, wait for done.
  task automatic run_op(input string tag, input bit o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    bit mdz, seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      end
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    model(o, x, y, mdz);
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
    check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(mdz));
    @(posedge clk); #1;
    check({tag, ".done_drop"}, 64'(bus.done), 64'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d busy=%0d",
             o, x, y, bus.hi, bus.lo, mdz, lat, bcnt);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    bit o, mdz;
    logic [31:0] x, y;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;

    #2;
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.dz", 64'(bus.div_zero), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    run_op("mul7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, lat, bcnt);
    check("mul7x-3.lat", 64'(lat), 64'd33);
    check("mul7x-3.busy_cycles", 64'(bcnt), 64'd32);
    check("mul7x-3.hi_const", 64'(bus.hi), 64'hFFFFFFFF);
    check("mul7x-3.lo_const", 64'(bus.lo), 64'hFFFFFFEB);

    run_op("div17/-5", 1'b1, 32'd17, 32'hFFFFFFFB, lat, bcnt);
    check("div17/-5.lo_const", 64'(bus.lo), 64'hFFFFFFFD);
    check("div17/-5.hi_const", 64'(bus.hi), 64'h00000002);
    run_op("div-17/5", 1'b1, 32'hFFFFFFEF, 32'd5, lat, bcnt);
    check("div-17/5.lo_const", 64'(bus.lo), 64'hFFFFFFFD);
    check("div-17/5.hi_const", 64'(bus.hi), 64'hFFFFFFFE);

    run_op("preload", 1'b1, 32'h0ACF1234, 32'h00002000, lat, bcnt);
    check("preload.hi_const", 64'(bus.hi), 64'h1234);
    check("preload.lo_const", 64'(bus.lo), 64'h5678);
    run_op("div0", 1'b1, 32'h11111111, 32'd0, lat, bcnt);
    check("div0.lat", 64'(lat), 64'd1);
    check("div0.busy_cycles", 64'(bcnt), 64'd0);
    check("div0.hi_const", 64'(bus.hi), 64'h1234);
    check("div0.lo_const", 64'(bus.lo), 64'h5678);

    run_op("divmin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    check("divmin/-1.lo_const", 64'(bus.lo), 64'h80000000);
    check("divmin/-1.hi_const", 64'(bus.hi), 64'h0);
    run_op("mulminxmin", 1'b0, 32'h80000000, 32'h80000000, lat, bcnt);
    check("mulminxmin.hi_const", 64'(bus.hi), 64'h40000000);
    check("mulminxmin.lo_const", 64'(bus.lo), 64'h0);

    // Restart attempt mid-operation must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h00012345; bus.b = 32'hFFFFF889;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.start = 1'b0;
      if (i == 10) begin bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd99; bus.b = 32'd3; end
      if (i == 11) begin bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h0; end
      if (bus.done) dcnt++;
    end
    model(1'b0, 32'h00012345, 32'hFFFFF889, mdz);
    check("restart.done_pulses", 64'(dcnt), 64'd1);
    check("restart.hi", 64'(bus.hi), 64'(m_hi));
    check("restart.lo", 64'(bus.lo), 64'(m_lo));
    $display("restart-ignored mult -> hi=%h lo=%h pulses=%0d", bus.hi, bus.lo, dcnt);

    // Asynchronous reset during a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h7FFFFFFF; bus.b = 32'h7FFFFFFF;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(bus.busy), 64'd0);
    check("midrst.hi", 64'(bus.hi), 64'd0);
    check("midrst.lo", 64'(bus.lo), 64'd0);
    check("midrst.done", 64'(bus.done), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    $display("reset asserted mid-RUN, outputs cleared");
    run_op("div100/7", 1'b1, 32'd100, 32'd7, lat, bcnt);
    check("div100/7.lo_const", 64'(bus.lo), 64'd14);
    check("div100/7.hi_const", 64'(bus.hi), 64'd2);
    check("div100/7.lat", 64'(lat), 64'd33);

    for (int k = 0; k < 24; k++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: y = -32'($urandom_range(1, 9));
        3: x = 32'h80000000;
        default: ;
      endcase
      run_op("rand", o, x, y, lat, bcnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
